// File: rtl/ntt_pkg.sv
// ntt_pkg: constants, FSM state encoding, modular arithmetic and twiddle tables shared by the
// forward and inverse NTT blocks (q = 17, N = 8, w = 2, psi = 6 so that psi^2 = w).
// The w^-k and psi^-n tables are generated at elaboration time rather than read from files.
package ntt_pkg;

  localparam int unsigned Q      = 17;
  localparam int unsigned N      = 8;
  localparam int unsigned LogQ   = 5;
  localparam int unsigned LogN   = 3;
  localparam int unsigned W      = 2;
  localparam int unsigned Psi    = 6;
  localparam int unsigned StageW = $clog2(LogN + 1);

  typedef logic [LogQ-1:0]   coef_t;
  typedef logic [LogN-1:0]   idx_t;
  typedef logic [StageW-1:0] stage_t;

  typedef enum logic [1:0] {
    StLoad    = 2'd0,
    StCompute = 2'd1,
    StOutput  = 2'd2
  } state_e;

  localparam logic [LogQ:0]     QSum  = (LogQ + 1)'(Q);
  localparam logic [2*LogQ-1:0] QProd = (2 * LogQ)'(Q);

  // (a + b) mod q for a, b < q: one conditional subtract.
  function automatic coef_t mod_add(coef_t a, coef_t b);
    logic [LogQ:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QSum) s = s - QSum;
    return s[LogQ-1:0];
  endfunction

  // (a - b) mod q for a, b < q: add q back when the difference would go negative.
  function automatic coef_t mod_sub(coef_t a, coef_t b);
    logic [LogQ:0] d;
    if (a < b) d = {1'b0, a} + QSum - {1'b0, b};
    else       d = {1'b0, a} - {1'b0, b};
    return d[LogQ-1:0];
  endfunction

  // (a * b) mod q with a full-width product.
  function automatic coef_t mod_mul(coef_t a, coef_t b);
    logic [2*LogQ-1:0] p;
    p = {{LogQ{1'b0}}, a} * {{LogQ{1'b0}}, b};
    p = p % QProd;
    return p[LogQ-1:0];
  endfunction

  function automatic idx_t bitrev(idx_t x);
    idx_t r;
    for (int unsigned i = 0; i < LogN; i++) r[i] = x[LogN-1-i];
    return r;
  endfunction

  // Elaboration-time only: b^e mod q.
  function automatic int unsigned pow_mod(int unsigned b, int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  // w^-k = w^(N-k) because w has order N.
  function automatic logic [N*LogQ-1:0] gen_w_inv_tab();
    logic [N*LogQ-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < N; k++) t[k*LogQ +: LogQ] = coef_t'(pow_mod(W, (N - k) % N));
    return t;
  endfunction

  // psi^-n = psi^(2N-n) because psi has order 2N.
  function automatic logic [N*LogQ-1:0] gen_phi_inv_tab();
    logic [N*LogQ-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < N; k++) t[k*LogQ +: LogQ] = coef_t'(pow_mod(Psi, 2 * N - k));
    return t;
  endfunction

  localparam logic [N*LogQ-1:0] WInvTab   = gen_w_inv_tab();
  localparam logic [N*LogQ-1:0] PhiInvTab = gen_phi_inv_tab();

endpackage

// File: rtl/intt_butterfly.sv
// intt_butterfly: combinational radix-2 butterfly (u, v, w) -> (u + v*w, u - v*w) mod q.
module intt_butterfly
  import ntt_pkg::*;
(
  input  logic [LogQ-1:0] u_i,
  input  logic [LogQ-1:0] v_i,
  input  logic [LogQ-1:0] w_i,
  output logic [LogQ-1:0] sum_o,
  output logic [LogQ-1:0] diff_o
);

  coef_t t;

  // Twiddle product shared by both outputs.
  always_comb begin
    t      = mod_mul(v_i, w_i);
    sum_o  = mod_add(u_i, t);
    diff_o = mod_sub(u_i, t);
  end

endmodule

// File: rtl/intt.sv
// intt: streaming inverse negacyclic NTT. Loads N coefficients in bit-reversed order, runs an
// in-place radix-2 DIT pass (one butterfly slot per cycle), then streams x[n] in natural order.
// Build option: define INTT_NINV_SCALE_EN to fold N^-1 into the output; otherwise outputs are
// N*x[n] mod q and the scale is left to downstream logic. Cycle timing is the same either way.
module intt
  import ntt_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [LogQ-1:0] poly_in,
  output logic            in_ready,
  output logic            out_valid,
  output logic [LogQ-1:0] poly_out,
  input  logic            out_ready
);

  localparam idx_t   CntMax    = idx_t'(N - 1);
  localparam stage_t StageDone = stage_t'(LogN);
  localparam stage_t StageTop  = stage_t'(LogN - 1);

  state_e state_q, state_d;
  idx_t   cnt_q, cnt_d;
  stage_t stage_q, stage_d;
  coef_t  buf_q [N];

  idx_t  half, pair_idx, tw_idx;
  logic  upper_half;
  coef_t tw, bf_sum, bf_diff, phi_inv;
  logic  load_we, bf_we;

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StOutput);

  // Stage addressing: partner at j+h, twiddle index (j mod h) * (N >> (s+1)).
  always_comb begin
    half       = idx_t'(1) << stage_q;
    pair_idx   = cnt_q + half;
    tw_idx     = (cnt_q & (half - idx_t'(1))) << (StageTop - stage_q);
    upper_half = (cnt_q & half) != '0;
    tw         = WInvTab[tw_idx * LogQ +: LogQ];
  end

  intt_butterfly u_butterfly (
    .u_i    (buf_q[cnt_q]),
    .v_i    (buf_q[pair_idx]),
    .w_i    (tw),
    .sum_o  (bf_sum),
    .diff_o (bf_diff)
  );

  // Next-state: LOAD counts beats, COMPUTE sweeps CNT per stage plus one idle cycle,
  // OUTPUT advances on each accepted beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    load_we = 1'b0;
    bf_we   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + idx_t'(1);
          if (cnt_q == CntMax) begin
            cnt_d   = '0;
            stage_d = '0;
            state_d = StCompute;
          end
        end
      end
      StCompute: begin
        if (stage_q >= StageDone) begin
          cnt_d   = '0;
          stage_d = '0;
          state_d = StOutput;
        end else begin
          // Only the lower index of each pair owns the butterfly.
          bf_we = !upper_half;
          cnt_d = cnt_q + idx_t'(1);
          if (cnt_q == CntMax) begin
            cnt_d   = '0;
            stage_d = stage_q + stage_t'(1);
          end
        end
      end
      StOutput: begin
        if (out_ready) begin
          cnt_d = cnt_q + idx_t'(1);
          if (cnt_q == CntMax) begin
            cnt_d   = '0;
            state_d = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  // Coefficient buffer: load writes or in-place butterfly writes; never cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && load_we) buf_q[cnt_q] <= poly_in;
    if (!reset && bf_we) begin
      buf_q[cnt_q]    <= bf_sum;
      buf_q[pair_idx] <= bf_diff;
    end
  end

  // Output twist by psi^-n, optionally scaled by N^-1.
  always_comb begin
    phi_inv = PhiInvTab[cnt_q * LogQ +: LogQ];
`ifdef INTT_NINV_SCALE_EN
    poly_out = mod_mul(mod_mul(buf_q[cnt_q], phi_inv), coef_t'(15));
`else
    poly_out = mod_mul(buf_q[cnt_q], phi_inv);
`endif
  end

endmodule

// File: tb/tb_intt.sv
// tb_intt: self-checking bench for intt against a direct-sum negacyclic NTT/INTT model.
module tb_intt;

  localparam int Q   = 17;
  localparam int NN  = 8;
  localparam int W   = 2;
  localparam int PSI = 6;  // psi^2 = w
`ifdef INTT_NINV_SCALE_EN
  localparam int SCALE = 15;
`else
  localparam int SCALE = 1;
`endif
  // Overall gain from a time-domain vector to the DUT output: N * S mod q.
  localparam int GAIN = (NN * SCALE) % Q;
  localparam int LAT  = 3 * NN + 1;

  typedef int vec_t [NN];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [4:0] poly_in = '0;
  logic       in_ready, out_valid;
  logic [4:0] poly_out;
  int         cycle = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  intt dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .poly_in   (poly_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .poly_out  (poly_out),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic int powm(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  function automatic int brev3(int x);
    return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
  endfunction

  // Forward negacyclic NTT by direct sum, emitted in bit-reversed stream order.
  task automatic ntt_stream(input vec_t a, output vec_t s);
    vec_t spec;
    int acc;
    for (int k = 0; k < NN; k++) begin
      acc = 0;
      for (int n = 0; n < NN; n++)
        acc = (acc + a[n] * powm(PSI, n) % Q * powm(W, (n * k) % NN)) % Q;
      spec[k] = acc;
    end
    for (int j = 0; j < NN; j++) s[j] = spec[brev3(j)];
  endtask

  // Inverse by direct sum from a bit-reversed stream, including the output scale S.
  task automatic intt_model(input vec_t s, output vec_t x);
    int acc, k;
    for (int n = 0; n < NN; n++) begin
      acc = 0;
      for (int j = 0; j < NN; j++) begin
        k = brev3(j);
        acc = (acc + s[j] * powm(W, (NN - (n * k) % NN) % NN)) % Q;
      end
      x[n] = acc * powm(PSI, 2 * NN - n) % Q * SCALE % Q;
    end
  endtask

  // Streams one vector; optional random in_valid gaps. Times are cycle counts after the edge.
  task automatic send(input vec_t s, input bit gaps, output int t_first, output int t_last,
                      output bit timeout);
    int n;
    timeout = 1'b0;
    t_first = -1;
    t_last  = -1;
    for (int i = 0; i < NN; i++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      poly_in  = 5'(s[i]);
      n = 0;
      while (in_ready !== 1'b1 && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 500) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (i == 0) t_first = cycle;
      t_last = cycle;
    end
    in_valid = 1'b0;
  endtask

  // Collects N output beats; optional random out_ready. Records stall stability and in_ready.
  task automatic collect(input bit bp, output vec_t got, output int t_valid, output int t_done,
                         output int unstable, output int ready_bad, output bit timeout);
    int k, n;
    bit held;
    logic [4:0] held_val;
    k = 0; n = 0; held = 1'b0; held_val = '0;
    t_valid = -1; t_done = -1; unstable = 0; ready_bad = 0; timeout = 1'b0;
    for (int i = 0; i < NN; i++) got[i] = -1;
    while (k < NN && n < 2000) begin
      out_ready = bp ? ($urandom_range(1, 0) == 1) : 1'b1;
      @(negedge clk);
      if (in_ready !== 1'b0) ready_bad++;
      if (out_valid === 1'b1) begin
        if (t_valid < 0) t_valid = cycle;
        if (held && poly_out !== held_val) unstable++;
        if (out_ready) begin
          got[k] = int'(poly_out);
          k++;
          held = 1'b0;
          if (k == NN) t_done = cycle + 1;
        end else begin
          held = 1'b1;
          held_val = poly_out;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    if (k < NN) timeout = 1'b1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_impulse();
    vec_t s, got;
    int tf, tl, tv, td, us, rb, exp;
    bit to1, to2;
    for (int i = 0; i < NN; i++) s[i] = 1;
    send(s, 1'b0, tf, tl, to1);
    collect(1'b0, got, tv, td, us, rb, to2);
    n_checks++;
    if (to1 || to2) begin
      n_fail++; $display("FAIL impulse_timeout: got %0d/%0d want 0/0", to1, to2);
      return;
    end
    for (int n = 0; n < NN; n++) begin
      exp = (n == 0) ? GAIN : 0;
      n_checks++;
      if (got[n] !== exp) begin
        n_fail++; $display("FAIL impulse_x[%0d]: got %0d want %0d", n, got[n], exp);
      end
    end
  endtask

  task automatic test_zero();
    vec_t s, got;
    int tf, tl, tv, td, us, rb;
    bit to1, to2;
    for (int i = 0; i < NN; i++) s[i] = 0;
    send(s, 1'b0, tf, tl, to1);
    collect(1'b0, got, tv, td, us, rb, to2);
    n_checks++;
    if (to1 || to2) begin
      n_fail++; $display("FAIL zero_timeout: got %0d/%0d want 0/0", to1, to2);
      return;
    end
    n_checks++;
    if (tv - tl !== LAT) begin
      n_fail++; $display("FAIL zero_latency: got %0d want %0d", tv - tl, LAT);
    end
    for (int n = 0; n < NN; n++) begin
      n_checks++;
      if (got[n] !== 0) begin
        n_fail++; $display("FAIL zero_x[%0d]: got %0d want 0", n, got[n]);
      end
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_return_load: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_round_trip();
    vec_t a, s, got;
    int tf, tl, tv, td, us, rb, exp;
    bit to1, to2, gaps, bp;
    for (int it = 0; it < 100; it++) begin
      for (int n = 0; n < NN; n++) a[n] = $urandom_range(Q - 1, 0);
      ntt_stream(a, s);
      gaps = $urandom_range(1, 0) == 1;
      bp   = $urandom_range(1, 0) == 1;
      send(s, gaps, tf, tl, to1);
      collect(bp, got, tv, td, us, rb, to2);
      n_checks++;
      if (to1 || to2) begin
        n_fail++; $display("FAIL rt_timeout[%0d]: got %0d/%0d want 0/0", it, to1, to2);
        return;
      end
      for (int n = 0; n < NN; n++) begin
        exp = a[n] * GAIN % Q;
        n_checks++;
        if (got[n] !== exp) begin
          n_fail++; $display("FAIL rt[%0d]_x[%0d]: got %0d want %0d", it, n, got[n], exp);
        end
      end
      n_checks++;
      if (rb !== 0) begin
        n_fail++; $display("FAIL rt[%0d]_in_ready_busy: got %0d cycles high want 0", it, rb);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t s, got, exp;
    int tf, tl, tv, td, us, rb;
    bit to1, to2;
    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < NN; j++) s[j] = $urandom_range(Q - 1, 0);
      intt_model(s, exp);
      send(s, 1'b1, tf, tl, to1);
      collect(1'b1, got, tv, td, us, rb, to2);
      n_checks++;
      if (to1 || to2) begin
        n_fail++; $display("FAIL bp_timeout[%0d]: got %0d/%0d want 0/0", it, to1, to2);
        return;
      end
      for (int n = 0; n < NN; n++) begin
        n_checks++;
        if (got[n] !== exp[n]) begin
          n_fail++; $display("FAIL bp[%0d]_x[%0d]: got %0d want %0d", it, n, got[n], exp[n]);
        end
      end
      n_checks++;
      if (us !== 0) begin
        n_fail++; $display("FAIL bp[%0d]_hold: got %0d changes while stalled want 0", it, us);
      end
      n_checks++;
      if (rb !== 0) begin
        n_fail++; $display("FAIL bp[%0d]_in_ready_busy: got %0d want 0", it, rb);
      end
    end
  endtask

  task automatic test_reset_mid_compute();
    vec_t s, got;
    int tf, tl, tv, td, us, rb, exp;
    bit to1, to2;
    for (int j = 0; j < NN; j++) s[j] = $urandom_range(Q - 1, 0);
    send(s, 1'b0, tf, tl, to1);
    // Edge k after the last accept leaves STAGE = k/8, CNT = k%8; k = 11 is STAGE 1, CNT 3.
    repeat (11) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_compute_flags: got ready=%b valid=%b want 0/0", in_ready, out_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_out_valid: got %b want 0", out_valid);
    end
    for (int i = 0; i < NN; i++) s[i] = 1;
    send(s, 1'b0, tf, tl, to1);
    collect(1'b0, got, tv, td, us, rb, to2);
    n_checks++;
    if (to1 || to2) begin
      n_fail++; $display("FAIL mid_impulse_timeout: got %0d/%0d want 0/0", to1, to2);
      return;
    end
    n_checks++;
    if (tv - tl !== LAT) begin
      n_fail++; $display("FAIL mid_impulse_latency: got %0d want %0d", tv - tl, LAT);
    end
    for (int n = 0; n < NN; n++) begin
      exp = (n == 0) ? GAIN : 0;
      n_checks++;
      if (got[n] !== exp) begin
        n_fail++; $display("FAIL mid_impulse_x[%0d]: got %0d want %0d", n, got[n], exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t a1, a2, s1, s2, got1, got2;
    int tf1, tl1, tf2, tl2, tv1, td1, tv2, td2, us, rb, exp;
    bit to1, to2, to3, to4;
    for (int n = 0; n < NN; n++) begin
      a1[n] = $urandom_range(Q - 1, 0);
      a2[n] = $urandom_range(Q - 1, 0);
    end
    ntt_stream(a1, s1);
    ntt_stream(a2, s2);
    send(s1, 1'b0, tf1, tl1, to1);
    fork
      collect(1'b0, got1, tv1, td1, us, rb, to2);
      send(s2, 1'b0, tf2, tl2, to3);
    join
    collect(1'b0, got2, tv2, td2, us, rb, to4);
    n_checks++;
    if (to1 || to2 || to3 || to4) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d%0d%0d%0d want 0000", to1, to2, to3, to4);
      return;
    end
    n_checks++;
    if (tf2 !== td1 + 1) begin
      n_fail++; $display("FAIL b2b_first_accept: got cycle %0d want %0d", tf2, td1 + 1);
    end
    for (int n = 0; n < NN; n++) begin
      exp = a1[n] * GAIN % Q;
      n_checks++;
      if (got1[n] !== exp) begin
        n_fail++; $display("FAIL b2b_first_x[%0d]: got %0d want %0d", n, got1[n], exp);
      end
      exp = a2[n] * GAIN % Q;
      n_checks++;
      if (got2[n] !== exp) begin
        n_fail++; $display("FAIL b2b_second_x[%0d]: got %0d want %0d", n, got2[n], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_zero();
    test_round_trip();
    test_backpressure();
    test_reset_mid_compute();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
